// File: rtl/sa_fifo_pkg.sv
// Shared defaults and types for the RAM-backed FIFO controller and its skid stage.
package sa_fifo_pkg;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_AW     = 7;
    localparam int DEF_DW     = 18;
    localparam int DEF_CW     = 8;
    localparam int SKID_DEPTH = 2;

    typedef logic [DEF_CW-1:0]                    cnt_t;
    typedef logic [$clog2(SKID_DEPTH+1)-1:0]      occ_t;
endpackage

// File: rtl/sa_fifo_skid2.sv
// Two-entry in-order output register stage; entry0 drives the consumer directly.
module sa_fifo_skid2
    import sa_fifo_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          vld,
    output logic [DW-1:0] data,
    output occ_t          occ
);
    logic [DW-1:0] d0, d1;
    occ_t          occ_q;
    logic          pop_ok;

    assign pop_ok = pop && (occ_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0    <= '0;
            d1    <= '0;
            occ_q <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (occ_q == '0) d0 <= push_data;
                    else             d1 <= push_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    d0    <= d1;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (occ_q == occ_t'(SKID_DEPTH)) begin
                        d0 <= d1;
                        d1 <= push_data;
                    end else begin
                        d0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vld  = (occ_q != '0);
    assign data = d0;
    assign occ  = occ_q;
endmodule

// File: rtl/sa_ram_rws_fifo_ctrl.sv
// FIFO controller sequencing an external 1-cycle-latency RAM, with a 2-entry skid on the read side.
module sa_ram_rws_fifo_ctrl
    import sa_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic [CW-1:0] fifo_count,
    output logic          idle
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic          rd_inflight;
    logic          rdy_en;
    logic          wr_acc, pop, skid_vld;
    occ_t          skid_occ, occ_after;

    // rdy_en keeps wr_prdy low while reset is held and for the edge it is released on.
    assign wr_prdy = rdy_en && (ram_cnt != CW'(DEPTH));
    assign wr_acc  = wr_pvld && wr_prdy;
    assign ram_we  = wr_acc;
    assign ram_wa  = wr_ptr;
    assign ram_di  = wr_pd;

    assign pop       = skid_vld && rd_prdy;
    assign occ_after = skid_occ - {1'b0, pop};
    // Credit check: skid entries left after this pop plus the word already in flight.
    assign ram_re    = (ram_cnt != '0) &&
                       (({1'b0, occ_after} + {2'b00, rd_inflight}) < 3'(SKID_DEPTH));
    assign ram_ra    = rd_ptr;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            rdy_en      <= 1'b0;
        end else begin
            rdy_en      <= 1'b1;
            rd_inflight <= ram_re;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (ram_re) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, ram_re})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    sa_fifo_skid2 #(.DW(DW)) u_skid (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .push      (rd_inflight),
        .push_data (ram_dout),
        .pop       (pop),
        .vld       (skid_vld),
        .data      (rd_pd),
        .occ       (skid_occ)
    );

    assign rd_pvld    = skid_vld;
    assign fifo_count = ram_cnt + CW'(rd_inflight) + CW'(skid_occ);
    assign idle       = (fifo_count == '0) && !ram_we;
endmodule

// File: tb/tb_sa_ram_rws_fifo_ctrl.sv
// Directed vector table plus multi-cycle sequences against a behavioural 128x18 RAM.
module tb_sa_ram_rws_fifo_ctrl;
    localparam int DW = 18;
    localparam int AW = 7;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_pvld, wr_prdy, rd_pvld, rd_prdy;
    logic [DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
    logic          ram_we, ram_re, idle;
    logic [AW-1:0] ram_wa, ram_ra;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    sa_ram_rws_fifo_ctrl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .wr_pvld         (wr_pvld),
        .wr_prdy         (wr_prdy),
        .wr_pd           (wr_pd),
        .rd_pvld         (rd_pvld),
        .rd_prdy         (rd_prdy),
        .rd_pd           (rd_pd),
        .ram_we          (ram_we),
        .ram_wa          (ram_wa),
        .ram_di          (ram_di),
        .ram_re          (ram_re),
        .ram_ra          (ram_ra),
        .ram_dout        (ram_dout),
        .fifo_count      (fifo_count),
        .idle            (idle)
    );

    logic [DW-1:0] mem [0:127];
    logic [AW-1:0] ra_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] sb [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_pd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic observe();
        chk("count_range", 32'(fifo_count <= 8'd130), 32'd1);
        if (prev_stall) begin
            chk("stall_vld", 32'(rd_pvld), 32'd1);
            chk("stall_pd", 32'(rd_pd), 32'(prev_pd));
        end
        if (wr_pvld && wr_prdy) sb.push_back(wr_pd);
        if (rd_pvld && rd_prdy) begin
            if (sb.size() == 0) chk("pop_when_empty", 32'd1, 32'd0);
            else                chk("order", 32'(rd_pd), 32'(sb.pop_front()));
        end
        prev_stall = rd_pvld && !rd_prdy;
        prev_pd    = rd_pd;
    endtask

    task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr);
        wr_pvld = wv;
        wr_pd   = wd;
        rd_prdy = rr;
        #1;
        observe();
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          e_wrdy, e_we, e_re;
        logic [AW-1:0] e_ra;
        logic          e_vld;
        logic [DW-1:0] e_pd;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nxt, pops, first, last;
        logic [DW-1:0] d;

        //       wv  wd        rr  wrdy we  re  ra  vld pd        cnt
        vecs[0]  = '{1, 18'h2A5F, 1, 1, 1, 0, 0, 0, 18'h0,    0};
        vecs[1]  = '{0, 18'h0,    1, 1, 0, 1, 0, 0, 18'h0,    1};
        vecs[2]  = '{0, 18'h0,    1, 1, 0, 0, 0, 0, 18'h0,    1};
        vecs[3]  = '{0, 18'h0,    1, 1, 0, 0, 0, 1, 18'h2A5F, 1};
        vecs[4]  = '{0, 18'h0,    1, 1, 0, 0, 0, 0, 18'h0,    0};
        vecs[5]  = '{1, 18'h111,  0, 1, 1, 0, 0, 0, 18'h0,    0};
        vecs[6]  = '{1, 18'h222,  0, 1, 1, 1, 1, 0, 18'h0,    1};
        vecs[7]  = '{0, 18'h0,    0, 1, 0, 1, 2, 0, 18'h0,    2};
        vecs[8]  = '{0, 18'h0,    0, 1, 0, 0, 0, 1, 18'h111,  2};
        vecs[9]  = '{0, 18'h0,    1, 1, 0, 0, 0, 1, 18'h111,  2};
        vecs[10] = '{0, 18'h0,    1, 1, 0, 0, 0, 1, 18'h222,  1};
        vecs[11] = '{0, 18'h0,    0, 1, 0, 0, 0, 0, 18'h0,    0};

        rst_n = 1'b0; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
        #2;
        chk("rst_wr_prdy", 32'(wr_prdy), 0);
        chk("rst_rd_pvld", 32'(rd_pvld), 0);
        chk("rst_rd_pd", 32'(rd_pd), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_re", 32'(ram_re), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_idle", 32'(idle), 1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wv, vecs[i].wd, vecs[i].rr);
            chk($sformatf("v%0d_wr_prdy", i), 32'(wr_prdy), 32'(vecs[i].e_wrdy));
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_ram_re", i), 32'(ram_re), 32'(vecs[i].e_re));
            if (vecs[i].e_re) chk($sformatf("v%0d_ram_ra", i), 32'(ram_ra), 32'(vecs[i].e_ra));
            chk($sformatf("v%0d_rd_pvld", i), 32'(rd_pvld), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) chk($sformatf("v%0d_rd_pd", i), 32'(rd_pd), 32'(vecs[i].e_pd));
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_idle", i), 32'(idle), 32'(vecs[i].e_cnt == 0 && !vecs[i].e_we));
            tick();
        end

        // Fill to DEPTH+2 with the consumer stalled.
        nxt = 0;
        for (int c = 0; c < 135; c++) begin
            drive(1'b1, DW'(nxt), 1'b0);
            if (wr_prdy) nxt++;
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk("fill_accepts", 32'(nxt), 130);
        chk("fill_count", 32'(fifo_count), 130);
        chk("fill_wr_prdy", 32'(wr_prdy), 0);
        tick();
        drive(1'b0, '0, 1'b1);
        chk("full_first_re", 32'(ram_re), 1);
        chk("full_prdy_same_cycle", 32'(wr_prdy), 0);
        tick();
        drive(1'b0, '0, 1'b1);
        chk("full_prdy_next_cycle", 32'(wr_prdy), 1);
        tick();
        for (int c = 0; c < 140; c++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        chk("fill_drained", 32'(sb.size()), 0);

        // Streaming at full rate.
        pops = 0; first = -1; last = -1;
        for (int c = 0; c < 510; c++) begin
            drive(c < 500, DW'(c + 1000), 1'b1);
            if (rd_pvld) begin
                pops++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        chk("stream_pops", 32'(pops), 500);
        chk("stream_latency", 32'(first), 3);
        chk("stream_no_bubble", 32'(last - first), 499);
        chk("stream_drained", 32'(sb.size()), 0);

        // Hold at 64 with a write and a pop every cycle.
        for (int c = 0; c < 64; c++) begin
            drive(1'b1, DW'(c + 18'h3000), 1'b0);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk("sim_pre_count", 32'(fifo_count), 64);
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, DW'(c + 18'h3100), 1'b1);
            chk("sim_count", 32'(fifo_count), 64);
            tick();
        end
        for (int c = 0; c < 80; c++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        chk("sim_drained", 32'(sb.size()), 0);

        // Random producer and consumer.
        for (int c = 0; c < 800; c++) begin
            d = DW'($urandom);
            drive(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
            tick();
        end
        for (int c = 0; c < 150; c++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        chk("rand_drained", 32'(sb.size()), 0);

        // Reset in the middle of traffic.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, DW'(c + 18'h2000), 1'b0);
            tick();
        end
        wr_pvld = 1'b1; rd_prdy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_rd_pvld", 32'(rd_pvld), 0);
        chk("mrst_count", 32'(fifo_count), 0);
        chk("mrst_ram_we", 32'(ram_we), 0);
        chk("mrst_ram_re", 32'(ram_re), 0);
        chk("mrst_idle", 32'(idle), 1);
        chk("mrst_wr_prdy", 32'(wr_prdy), 0);
        sb.delete();
        prev_stall = 1'b0;
        wr_pvld = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        drive(1'b0, '0, 1'b1);
        chk("mrst_after_prdy", 32'(wr_prdy), 1);
        tick();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, 1'b1);
            chk("mrst_no_old_data", 32'(rd_pvld), 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
